// File: rtl/pcileech_tx_gearbox.sv
// Host-bound tx path: wide-word gearbox into a 32-bit FIFO, with FTDI MAGIC pad-burst insertion.
// Define PCILEECH_TX_STATS_EN to add the stat_words / stat_pads counters.
module pcileech_tx_gearbox #(
  parameter int          IN_WIDTH    = 256,
  parameter int          DEPTH_LOG2  = 6,
  parameter logic [31:0] MAGIC_WORD  = 32'h66665555,
  parameter int          MAGIC_COUNT = 5,
  parameter int          PROG_EMPTY  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IN_WIDTH-1:0] din,
  input  logic                din_valid,
  output logic                din_ready,
  input  logic                ft_txe_n,
  output logic [31:0]         dout,
  output logic                dout_valid,
  output logic                dout_empty,
  input  logic                dout_rd_en,
  output logic                pad_active
`ifdef PCILEECH_TX_STATS_EN
  ,
  output logic [31:0]         stat_words,
  output logic [15:0]         stat_pads
`endif
);

  localparam int N  = IN_WIDTH / 32;
  localparam int LW = DEPTH_LOG2 + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(2 ** DEPTH_LOG2);
  localparam logic [LW-1:0] N_L     = LW'(N);
  localparam logic [LW-1:0] PE_L    = LW'(PROG_EMPTY);
  localparam logic [LW-1:0] MC_L    = LW'(MAGIC_COUNT);
  localparam logic [4:0]    N_LAST  = 5'(N - 1);
  localparam logic [4:0]    MC_LAST = 5'(MAGIC_COUNT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SLICE = 2'd1;
  localparam logic [1:0] S_PAD   = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [IN_WIDTH-1:0] hold_q, hold_d;
  logic                arm_q, arm_d;
  logic                txe_q;
  logic                rdy_q, rdy_d;
  logic [LW-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
  logic [31:0]         dout_q;
  logic                dvld_q;
  logic [31:0]         mem [2**DEPTH_LOG2];

  logic [LW-1:0] level, free, free_d;
  logic          empty, full, accept, pad_go, wr_en, rd_en, pad_done;
  logic [31:0]   wr_data;

  always_comb begin
    level    = wptr_q - rptr_q;
    free     = DEPTH_L - level;
    empty    = (level == '0);
    full     = (level == DEPTH_L);
    accept   = din_valid && rdy_q;
    // Pad only arms with din_valid low, so a waiting data word always wins.
    pad_go   = (MAGIC_COUNT != 0) && arm_q && (state_q == S_IDLE) && (level <= PE_L) &&
               txe_q && !din_valid && (free >= MC_L);
    wr_en    = (state_q == S_SLICE) || (state_q == S_PAD);
    wr_data  = (state_q == S_PAD) ? MAGIC_WORD : hold_q[31:0];
    rd_en    = dout_rd_en && !empty;
    pad_done = (state_q == S_PAD) && (cnt_q == MC_LAST);

    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    arm_d   = arm_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          hold_d  = din;
          cnt_d   = '0;
          state_d = S_SLICE;
        end else if (pad_go) begin
          cnt_d   = '0;
          state_d = S_PAD;
        end
      end
      S_SLICE: begin
        hold_d = hold_q >> 32;
        cnt_d  = cnt_q + 5'd1;
        arm_d  = 1'b1;
        if (cnt_q == N_LAST) state_d = S_IDLE;
      end
      S_PAD: begin
        cnt_d = cnt_q + 5'd1;
        if (pad_done) begin
          state_d = S_IDLE;
          arm_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    wptr_d = wptr_q + {{(LW-1){1'b0}}, wr_en};
    rptr_d = rptr_q + {{(LW-1){1'b0}}, rd_en};
    // din_ready is registered, so it is computed from next-cycle state and level.
    free_d = DEPTH_L - (wptr_d - rptr_d);
    rdy_d  = (state_d == S_IDLE) && (free_d >= N_L);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
      arm_q   <= 1'b1;
      txe_q   <= 1'b0;
      rdy_q   <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      dout_q  <= '0;
      dvld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      arm_q   <= arm_d;
      txe_q   <= ft_txe_n;
      rdy_q   <= rdy_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      dvld_q  <= rd_en;
      if (rd_en) dout_q <= mem[rptr_q[DEPTH_LOG2-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr_q[DEPTH_LOG2-1:0]] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en) assert (!full) else $error("tx_gearbox: write into full FIFO");
  end

`ifdef PCILEECH_TX_STATS_EN
  logic [31:0] words_q;
  logic [15:0] pads_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      words_q <= '0;
      pads_q  <= '0;
    end else begin
      if (state_q == S_SLICE) words_q <= words_q + 32'd1;
      if (pad_done && (pads_q != 16'hFFFF)) pads_q <= pads_q + 16'd1;
    end
  end

  assign stat_words = words_q;
  assign stat_pads  = pads_q;
`endif

  assign din_ready  = rdy_q;
  assign dout       = dout_q;
  assign dout_valid = dvld_q;
  assign dout_empty = empty;
  assign pad_active = (state_q == S_PAD);

endmodule
